multicyc_mdu: RTL
=================

Name: multicyc_mdu

Overview:
Parametrised iterative multiply/divide unit for the multi-cycle MIPS core. It executes MULT, MULTU, DIV and DIVU over WIDTH iterations and owns the architectural HI/LO registers, including the MTHI/MTLO write path.
The core's control unit stalls in an MDU-wait state while busy is high. MFHI/MFLO read hi/lo directly.
Intended as the reusable arithmetic successor to the single-cycle ALU path, and the basis for a future pipelined core.

Parameters:
WIDTH, 32, operand/HI/LO width; even, >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
start  in  1  begin operation; accepted only in IDLE
op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
cancel  in  1  abort in-flight operation (exception flush)
wr_hi  in  1  MTHI write strobe
wr_lo  in  1  MTLO write strobe
wr_data  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in flight
done  out  1  one-cycle pulse; hi/lo hold the new result
div_by_zero  out  1  pulses with done when a divide had b==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy, done and div_by_zero = 0; hi = lo = 0. Reset mid-operation aborts it, and no done is produced.
- States:
  - IDLE: start -> CALC. Latch |a|, |b| for signed ops, raw values for unsigned ops. Latch result-sign and remainder-sign flags. Counter = WIDTH.
  - CALC: one radix-2 step per cycle; counter decrements; at counter==1 -> FIX.
  - FIX: apply sign correction; write hi/lo; -> IDLE. done is registered, so it goes high in the following cycle.
- Timing (macro off): start sampled in cycle 0. busy=1 in cycles 1..WIDTH+1. done=1 in cycle WIDTH+2, with hi/lo already updated and busy=0.
- start is ignored while busy. start in the done cycle is accepted.
- Multiply: shift-add, 2*WIDTH product. hi = upper half, lo = lower half. Signed result is negated when the operand signs differ.
- Divide: restoring.
  - lo = quotient, truncated toward zero.
  - hi = remainder, taking the sign of the dividend.
  - MIN/-1: lo = MIN, hi = 0 (natural wrap; no trap).
  - b == 0: lo = all ones, hi = a (unmodified), div_by_zero pulses with done. Latency unchanged.
- cancel while busy: state -> IDLE at the next edge; hi/lo unchanged; no done.
  - cancel and start in the same IDLE cycle: start wins, cancel is ignored.
- wr_hi/wr_lo apply only when busy==0, taking effect at the next edge. Ignored while busy.
  - wr_hi/wr_lo with start in the same cycle: the write applies, and the result later overwrites it.
- a, b and op may change after the start cycle without affecting the result.

Optional Feature:
MDU_EARLY_OUT_EN:
- Defined, multiply: CALC exits to FIX as soon as the remaining shifted multiplier is zero (minimum 1 CALC cycle).
- Defined, divide-by-zero: CALC is skipped; done arrives in cycle 3.
- Divide by a non-zero b always takes full latency.
- Undefined: fixed latency for every op. Results are identical in both builds.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_e {MdMult, MdMultu, MdDiv, MdDivu}
  - mdu_state_e {MdIdle, MdCalc, MdFix}
  - helper is_signed_op()
- Sub-module mdu_step: combinational single iteration. Inputs are mode, accumulator, operand and counter; outputs are the next accumulator and operand. The top holds the FSM, counter, sign flags and HI/LO.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7 -> done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-33.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with start asserted in the done cycle -> second done arrives exactly 34 cycles later.
3. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 coincident with done.
5. Preload hi=0x11 via MTHI. Start DIV and assert cancel in cycle 10 -> busy=0 in cycle 11, no done, hi=0x11. A start pulse during busy is ignored (exactly one done per accepted start).
6. MULT in flight: wr_lo in cycle 3 is ignored. reset in cycle 5 -> hi=lo=0, busy=0, done never pulses.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: opcodes, FSM states, op classification.
package mdu_pkg;

  typedef enum logic [1:0] {
    MdMult  = 2'd0,
    MdMultu = 2'd1,
    MdDiv   = 2'd2,
    MdDivu  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdCalc = 2'd1,
    MdFix  = 2'd2
  } mdu_state_e;

  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == MdMult) || (op == MdDiv);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on unsigned magnitudes.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  mdu_op_e                mode_i,
  input  logic [CNT_W-1:0]       cnt_i,
  input  logic [2*WIDTH-1:0]     acc_i,
  input  logic [3*WIDTH-1:0]     opr_i,
  output logic [2*WIDTH-1:0]     acc_o,
  output logic [3*WIDTH-1:0]     opr_o
);

  localparam int W = WIDTH;

  // Multiply: opr = {multiplier, multiplicand shifted left (2W)}; divide: opr[W-1:0] = divisor.
  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic [W-1:0]   mplr;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] sum;

  always_comb begin
    acc_o  = acc_i;
    opr_o  = opr_i;
    rem_sh = acc_i[2*W-1:W-1];
    diff   = rem_sh - {1'b0, opr_i[W-1:0]};
    mplr   = opr_i[3*W-1:2*W];
    mcand  = opr_i[2*W-1:0];
    sum    = acc_i + (mplr[0] ? mcand : '0);
    if (cnt_i != '0) begin
      if (is_div_op(mode_i)) begin
        if (!diff[W]) acc_o = {diff[W-1:0], acc_i[W-2:0], 1'b1};
        else          acc_o = {acc_i[2*W-2:0], 1'b0};
      end else begin
        acc_o = sum;
        opr_o = {1'b0, mplr[W-1:1], mcand[2*W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/multicyc_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Define MDU_EARLY_OUT_EN to let
// multiplies finish once the multiplier is exhausted and divide-by-zero skip iterating.
module multicyc_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W = WIDTH;

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d, op_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_neg_q, res_neg_d, rem_neg_q, rem_neg_d, dbz_q, dbz_d;
  logic [2*W-1:0]   acc_q, acc_d, acc_nx;
  logic [3*W-1:0]   opr_q, opr_d, opr_nx;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, div_by_zero_q, div_by_zero_d;
  logic             sgn;
  logic [W-1:0]     abs_a, abs_b, dbz_mag;

  mdu_step #(.WIDTH(W), .CNT_W(CNT_W)) u_step (
    .mode_i (op_q),
    .cnt_i  (cnt_q),
    .acc_i  (acc_q),
    .opr_i  (opr_q),
    .acc_o  (acc_nx),
    .opr_o  (opr_nx)
  );

  // A zero divisor leaves |a| in the remainder half, or untouched in the low half when iterations are skipped.
`ifdef MDU_EARLY_OUT_EN
  assign dbz_mag = acc_q[W-1:0];
`else
  assign dbz_mag = acc_q[2*W-1:W];
`endif

  always_comb begin
    op_in = mdu_op_e'(op);
    sgn   = is_signed_op(op_in);
    abs_a = (sgn && a[W-1]) ? -a : a;
    abs_b = (sgn && b[W-1]) ? -b : b;

    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    res_neg_d     = res_neg_q;
    rem_neg_d     = rem_neg_q;
    dbz_d         = dbz_q;
    acc_d         = acc_q;
    opr_d         = opr_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;
    div_by_zero_d = 1'b0;

    case (state_q)
      MdIdle: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          state_d   = MdCalc;
          op_d      = op_in;
          cnt_d     = CNT_W'(W);
          res_neg_d = sgn && (a[W-1] ^ b[W-1]);
          rem_neg_d = sgn && a[W-1];
          dbz_d     = is_div_op(op_in) && (b == '0);
          if (is_div_op(op_in)) begin
            acc_d = {{W{1'b0}}, abs_a};
            opr_d = {{(2*W){1'b0}}, abs_b};
          end else begin
            acc_d = '0;
            opr_d = {abs_b, {W{1'b0}}, abs_a};
          end
        end
      end
      MdCalc: begin
        acc_d = acc_nx;
        opr_d = opr_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MdFix;
`ifdef MDU_EARLY_OUT_EN
        if (!is_div_op(op_q) && (opr_nx[3*W-1:2*W] == '0)) state_d = MdFix;
        if (dbz_q) begin
          state_d = MdFix;
          acc_d   = acc_q;
        end
`endif
        if (cancel) state_d = MdIdle;
      end
      MdFix: begin
        state_d = MdIdle;
        if (!cancel) begin
          done_d        = 1'b1;
          div_by_zero_d = dbz_q;
          if (dbz_q) begin
            lo_d = '1;
            hi_d = rem_neg_q ? -dbz_mag : dbz_mag;
          end else if (is_div_op(op_q)) begin
            lo_d = res_neg_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
            hi_d = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
          end else begin
            {hi_d, lo_d} = res_neg_q ? -acc_q : acc_q;
          end
        end
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= MdIdle;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q      <= op_d;
    cnt_q     <= cnt_d;
    res_neg_q <= res_neg_d;
    rem_neg_q <= rem_neg_d;
    dbz_q     <= dbz_d;
    acc_q     <= acc_d;
    opr_q     <= opr_d;
  end

  assign busy        = (state_q != MdIdle);
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
